timer_array: RTL and testbench
==============================

Name: timer_array

Overview:
- Parametrised successor to the single-channel Timer peripheral on the Bridge device bus.
- Provides N_CH independent down-counters behind one register window.
- Each channel supports one-shot or periodic mode, with a per-channel interrupt mask.
- One aggregated IRQ output feeds a HWInt bit; a sticky pending register is write-1-to-clear.

Parameters:
- N_CH, 4, number of channels; legal range 1..15.
- CNT_W, 32, counter/PRESET width; register reads are zero-extended to 32 bits.
- PRESCALE_W, 8, prescaler width; used only with TIMER_ARRAY_PRESCALE_EN.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- Addr  in  32  byte address from Bridge (DEV_Addr). Only Addr[7:2] is decoded.
- WE  in  1  word write enable.
- Din  in  32  write data.
- Dout  out  32  combinational read data for Addr.
- IRQ  out  1  OR of all pending bits.

Behaviour:
- Reset: CTRL, PRESET, COUNT, PRESCALE and PENDING are all 0. Every FSM is in IDLE. IRQ=0, and Dout is the decode of Addr, so it is 0 for any register.
- Register map. Channel c lives at Addr[7:4]=c:
  - 0x0 CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 periodic, 1x treated as one-shot), [3] IM. Other bits read 0.
  - 0x4 PRESET: read/write.
  - 0x8 COUNT: read-only; writes are ignored.
  - 0xC PRESCALE: see Optional Feature.
  - 0xF0 PENDING: bit c = channel c pending. Writing 1 clears that bit; writing 0 has no effect.
  - Channels c>=N_CH and unused offsets read 0 and ignore writes.
- Writes commit on the rising edge with WE=1. Reads are combinational with no wait state.
- Per-channel FSM, states IDLE, LOAD, CNT, INT:
  - IDLE: COUNT holds. Go to LOAD when EN=1.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT: if EN=0, go to IDLE and COUNT holds. Otherwise, if COUNT>1 then COUNT<=COUNT-1. Otherwise COUNT<=0, go to INT, and set PENDING[c] on the same edge if IM=1.
  - INT: in one-shot mode, EN<=0 and go to IDLE. In periodic mode, go to LOAD.
- Timing:
  - EN written at edge t: LOAD during cycle t+1, COUNT=PRESET after edge t+1.
  - PRESET=P>=1: PENDING is set at edge t+P+1.
  - Periodic period is max(P,1)+2 cycles.
  - P=0 behaves as P=1.
- PRESET writes take effect at the next LOAD; the active countdown is unaffected.
- A CTRL write with EN=0 stops the channel at the next edge. A CTRL write with EN=1 while in CNT changes MODE/IM without restarting.
- Simultaneous events:
  - A software CTRL write in the same cycle as the INT-state EN clear: software value wins.
  - A PENDING write-1-clear in the same cycle as a hardware set: the set wins.
  - IM=0: PENDING is never set by that channel. Clearing IM does not clear an already pending bit.
- Reset asserted mid-count returns everything to the reset values on that edge.
- COUNT never underflows. CNT_W arithmetic is modulo-free because of the >1 check.

Optional Feature:
- Macro: TIMER_ARRAY_PRESCALE_EN.
- Enabled:
  - PRESCALE register (PRESCALE_W bits) is read/write per channel.
  - A prescale counter, reloaded in LOAD, gates CNT decrements to once every PRESCALE+1 cycles.
  - The final COUNT<=0/INT step is also gated.
- Disabled:
  - Offset 0xC reads 0 and ignores writes.
  - Decrement occurs every CNT cycle.

Decomposition:
- Package timer_array_pkg holds:
  - the state enum (IDLE/LOAD/CNT/INT);
  - register offset constants (CTRL 0x0, PRESET 0x4, COUNT 0x8, PRESCALE 0xC, PENDING 0xF0);
  - CTRL bit indices and MODE encodings.
- Sub-module timer_channel contains one FSM plus its CTRL/PRESET/COUNT/PRESCALE registers and exports a pend_set pulse.
- The top level timer_array instantiates N_CH channels with a generate block. It also owns the read mux, write decode and PENDING register.

Test Plan:
- Reset, then read 0x00..0x3C and 0xF0 -> all 0; IRQ=0.
- ch0 PRESET=5, CTRL=0x9 (EN, one-shot, IM) at edge t -> COUNT reads 5,4,3,2,1,0. PENDING=0x1 and IRQ=1 at edge t+6. CTRL reads 0x8 afterwards; COUNT stays 0.
- ch2 PRESET=3, CTRL=0xB (periodic, IM) -> PENDING[2] rises every 5 cycles. Write 0xF0=0x4 between events -> bit clears. A clear coincident with a set leaves the bit set.
- ch1 PRESET=10 counting; write CTRL=0 when COUNT=6 -> COUNT holds 5; no IRQ. Rewrite EN -> reload to 10.
- ch3 IM=0, one-shot PRESET=2 -> EN self-clears, PENDING stays 0. Write to 0x48 (COUNT) -> ignored. Read channel 5 (N_CH=4) -> 0.
- With TIMER_ARRAY_PRESCALE_EN: ch0 PRESCALE=3, PRESET=2 -> decrements every 4 cycles; PENDING set 9 cycles after EN write. Without the macro, 0x0C reads 0.

Source files
------------

// File: rtl/timer_array_pkg.sv
// rtl/timer_array_pkg.sv - shared types and register map constants for timer_array
package timer_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_PRESET   = 8'h04;
    localparam logic [7:0] REG_COUNT    = 8'h08;
    localparam logic [7:0] REG_PRESCALE = 8'h0C;
    localparam logic [7:0] REG_PENDING  = 8'hF0;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

endpackage

// File: rtl/timer_array_if.sv
// rtl/timer_array_if.sv - Bridge device bus port bundle for timer_array
interface timer_array_if;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, output WE, output Din, input Dout, input IRQ);
    modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one down-counter channel with CTRL/PRESET/COUNT/PRESCALE registers
// Optional prescaler enabled by TIMER_ARRAY_PRESCALE_EN.
module timer_channel
    import timer_array_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_ctrl,
    input  logic                  wr_preset,
    input  logic                  wr_prescale,
    input  logic [3:0]            ctrl_wdata,
    input  logic [CNT_W-1:0]      preset_wdata,
    input  logic [PRESCALE_W-1:0] prescale_wdata,
    output logic [3:0]            ctrl_q,
    output logic [CNT_W-1:0]      preset_q,
    output logic [CNT_W-1:0]      count_q,
    output logic [PRESCALE_W-1:0] prescale_q,
    output logic                  pend_set
);

    state_t           state, state_n;
    logic             en;
    logic [1:0]       mode;
    logic             im;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count, count_n;
    logic             en_clr;
    logic             tick;

`ifdef TIMER_ARRAY_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] psc_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= '0;
            psc_cnt  <= '0;
        end else begin
            if (wr_prescale) prescale <= prescale_wdata;
            if (state == ST_LOAD) begin
                psc_cnt <= prescale;
            end else if (state == ST_CNT && en) begin
                psc_cnt <= tick ? prescale : psc_cnt - 1'b1;
            end
        end
    end

    assign tick       = (psc_cnt == '0);
    assign prescale_q = prescale;
`else
    wire unused_psc = &{1'b0, wr_prescale, prescale_wdata};

    assign tick       = 1'b1;
    assign prescale_q = '0;
`endif

    // IDLE looks at the EN being written this cycle so LOAD follows the write edge directly
    always_comb begin
        state_n  = state;
        count_n  = count;
        en_clr   = 1'b0;
        pend_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_ctrl ? ctrl_wdata[CTRL_EN] : en) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                count_n = preset;
                state_n = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_n = ST_IDLE;
                end else if (tick) begin
                    if (count > CNT_W'(1)) begin
                        count_n = count - CNT_W'(1);
                    end else begin
                        count_n  = '0;
                        state_n  = ST_INT;
                        pend_set = im;
                    end
                end
            end
            ST_INT: begin
                if (mode == MODE_PERIODIC) begin
                    state_n = ST_LOAD;
                end else begin
                    en_clr  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // a software CTRL write takes priority over the one-shot EN clear
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            preset <= '0;
            en     <= 1'b0;
            mode   <= MODE_ONESHOT;
            im     <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            if (wr_preset) preset <= preset_wdata;
            if (wr_ctrl) begin
                en   <= ctrl_wdata[CTRL_EN];
                mode <= ctrl_wdata[CTRL_MODE_HI:CTRL_MODE_LO];
                im   <= ctrl_wdata[CTRL_IM];
            end else if (en_clr) begin
                en <= 1'b0;
            end
        end
    end

    assign ctrl_q   = {im, mode, en};
    assign preset_q = preset;
    assign count_q  = count;

endmodule

// File: rtl/timer_array.sv
// rtl/timer_array.sv - N_CH-channel timer array with shared register window and aggregated IRQ
// Optional per-channel prescaler enabled by TIMER_ARRAY_PRESCALE_EN.
module timer_array
    import timer_array_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    timer_array_if.slave  bus
);

    logic [3:0]            sel_ch;
    logic [7:0]            sel_off;
    logic                  is_pend;
    logic [N_CH-1:0]       pending;
    logic [N_CH-1:0]       pend_set;
    logic [N_CH-1:0]       pend_clr;
    logic [31:0]           rdata;

    logic [3:0]            ctrl_q     [N_CH];
    logic [CNT_W-1:0]      preset_q   [N_CH];
    logic [CNT_W-1:0]      count_q    [N_CH];
    logic [PRESCALE_W-1:0] prescale_q [N_CH];

    wire unused_ok = &{1'b0, bus.Addr[31:8], bus.Addr[1:0], bus.Din};

    assign sel_ch  = bus.Addr[7:4];
    assign sel_off = {4'h0, bus.Addr[3:2], 2'b00};
    assign is_pend = (bus.Addr[7:2] == REG_PENDING[7:2]);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic ch_wr;
        assign ch_wr = bus.WE && (sel_ch == 4'(c));

        timer_channel #(
            .CNT_W      (CNT_W),
            .PRESCALE_W (PRESCALE_W)
        ) u_ch (
            .clk            (clk),
            .reset          (reset),
            .wr_ctrl        (ch_wr && sel_off == REG_CTRL),
            .wr_preset      (ch_wr && sel_off == REG_PRESET),
            .wr_prescale    (ch_wr && sel_off == REG_PRESCALE),
            .ctrl_wdata     (bus.Din[3:0]),
            .preset_wdata   (bus.Din[CNT_W-1:0]),
            .prescale_wdata (bus.Din[PRESCALE_W-1:0]),
            .ctrl_q         (ctrl_q[c]),
            .preset_q       (preset_q[c]),
            .count_q        (count_q[c]),
            .prescale_q     (prescale_q[c]),
            .pend_set       (pend_set[c])
        );
    end

    assign pend_clr = (bus.WE && is_pend) ? bus.Din[N_CH-1:0] : '0;

    // a hardware set lands even if software clears the same bit this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end

    always_comb begin
        rdata = '0;
        if (is_pend) begin
            rdata[N_CH-1:0] = pending;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (sel_ch == 4'(c)) begin
                    case (sel_off)
                        REG_CTRL:     rdata[3:0]            = ctrl_q[c];
                        REG_PRESET:   rdata[CNT_W-1:0]      = preset_q[c];
                        REG_COUNT:    rdata[CNT_W-1:0]      = count_q[c];
                        REG_PRESCALE: rdata[PRESCALE_W-1:0] = prescale_q[c];
                        default:      rdata                 = '0;
                    endcase
                end
            end
        end
    end

    assign bus.Dout = rdata;
    assign bus.IRQ  = |pending;

endmodule

// File: tb/tb_timer_array.sv
// tb/tb_timer_array.sv - self-checking bench for timer_array
module tb_timer_array;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    timer_array_if bus ();

    timer_array #(
        .N_CH       (4),
        .CNT_W      (32),
        .PRESCALE_W (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.WE   = 1'b0;
        bus.Addr = a;
        #1;
        check(name, bus.Dout, exp);
    endtask

    task automatic irq_chk(input string name, input logic exp);
        check(name, {31'd0, bus.IRQ}, {31'd0, exp});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.Addr = a;
        bus.Din  = d;
        bus.WE   = 1'b1;
        @(posedge clk);
        #1;
        bus.WE   = 1'b0;
        bus.Din  = '0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        bus.Addr = '0;
        bus.Din  = '0;
        bus.WE   = 1'b0;

        vecs[0]  = '{"preset0_rw",     32'h04, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{"preset2_rw",     32'h24, 32'h12345678, 32'h12345678};
        vecs[2]  = '{"ctrl0_upper",    32'h00, 32'hFFFFFFF0, 32'h00000000};
        vecs[3]  = '{"ctrl2_mode_im",  32'h20, 32'h0000000E, 32'h0000000E};
        vecs[4]  = '{"count2_ro",      32'h28, 32'h0000AAAA, 32'h00000000};
        vecs[5]  = '{"ch5_ignored",    32'h54, 32'h00000077, 32'h00000000};
        vecs[6]  = '{"ch14_ignored",   32'hE4, 32'h00000055, 32'h00000000};
        vecs[7]  = '{"unused_f4",      32'hF4, 32'hFFFFFFFF, 32'h00000000};
        vecs[8]  = '{"pending_w1c_0",  32'hF0, 32'h0000000F, 32'h00000000};
        vecs[9]  = '{"ctrl2_clear",    32'h20, 32'h00000000, 32'h00000000};
        vecs[10] = '{"preset0_clear",  32'h04, 32'h00000000, 32'h00000000};
        vecs[11] = '{"preset2_clear",  32'h24, 32'h00000000, 32'h00000000};

        cyc(3);
        @(negedge clk);
        reset = 1'b0;
        cyc(1);

        for (int a = 0; a < 16; a++) rd_chk("reset_reg", 32'(a * 4), 32'h0);
        rd_chk("reset_pending", 32'hF0, 32'h0);
        irq_chk("reset_irq", 1'b0);

        for (int i = 0; i < 12; i++) begin
            wr(vecs[i].addr, vecs[i].din);
            rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp);
        end
        irq_chk("vec_irq", 1'b0);

        // ch0 one-shot, IM: COUNT walks 5..0, PENDING at edge t+6
        wr(32'h04, 32'd5);
        wr(32'h00, 32'h9);
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            rd_chk("ch0_count", 32'h08, 32'(5 - k));
            if (k == 4) rd_chk("ch0_pend_early", 32'hF0, 32'h0);
        end
        rd_chk("ch0_pend", 32'hF0, 32'h1);
        irq_chk("ch0_irq", 1'b1);
        cyc(1);
        rd_chk("ch0_ctrl_selfclr", 32'h00, 32'h8);
        cyc(3);
        rd_chk("ch0_count_hold", 32'h08, 32'h0);
        wr(32'hF0, 32'h1);
        rd_chk("ch0_pend_clr", 32'hF0, 32'h0);
        irq_chk("ch0_irq_clr", 1'b0);

        // ch2 periodic P=3: sets at t+4, t+9, t+14
        wr(32'h24, 32'd3);
        wr(32'h20, 32'hB);
        cyc(3);
        rd_chk("ch2_pend_t3", 32'hF0, 32'h0);
        cyc(1);
        rd_chk("ch2_pend_t4", 32'hF0, 32'h4);
        wr(32'hF0, 32'h4);
        rd_chk("ch2_clr_t5", 32'hF0, 32'h0);
        cyc(3);
        rd_chk("ch2_pend_t8", 32'hF0, 32'h0);
        wr(32'hF0, 32'h4);
        rd_chk("ch2_set_wins_t9", 32'hF0, 32'h4);
        wr(32'hF0, 32'h4);
        rd_chk("ch2_clr_t10", 32'hF0, 32'h0);
        cyc(3);
        rd_chk("ch2_pend_t13", 32'hF0, 32'h0);
        cyc(1);
        rd_chk("ch2_period_t14", 32'hF0, 32'h4);
        wr(32'h20, 32'h0);
        cyc(4);
        wr(32'hF0, 32'h4);
        cyc(6);
        rd_chk("ch2_stopped", 32'hF0, 32'h0);
        irq_chk("ch2_irq_off", 1'b0);

        // ch1 stop mid-count, then restart reloads PRESET
        wr(32'h14, 32'd10);
        wr(32'h10, 32'h9);
        cyc(5);
        rd_chk("ch1_count6", 32'h18, 32'd6);
        wr(32'h10, 32'h0);
        rd_chk("ch1_count5", 32'h18, 32'd5);
        cyc(8);
        rd_chk("ch1_hold5", 32'h18, 32'd5);
        irq_chk("ch1_no_irq", 1'b0);
        wr(32'h14, 32'd20);
        wr(32'h10, 32'h9);
        rd_chk("ch1_load_cycle", 32'h18, 32'd5);
        cyc(1);
        rd_chk("ch1_reload", 32'h18, 32'd20);
        wr(32'h10, 32'h0);
        cyc(2);

        // ch3 IM=0 one-shot: EN self-clears, never pends
        wr(32'h34, 32'd2);
        wr(32'h30, 32'h1);
        cyc(6);
        rd_chk("ch3_ctrl", 32'h30, 32'h0);
        rd_chk("ch3_count", 32'h38, 32'h0);
        rd_chk("ch3_no_pend", 32'hF0, 32'h0);
        irq_chk("ch3_no_irq", 1'b0);
        wr(32'h48, 32'h1234);
        rd_chk("count_ch4_wr", 32'h48, 32'h0);
        rd_chk("ch5_read", 32'h50, 32'h0);
        rd_chk("ch5_preset", 32'h54, 32'h0);

        // reset asserted mid-count
        wr(32'h04, 32'd7);
        wr(32'h00, 32'h9);
        cyc(3);
        @(negedge clk);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        rd_chk("rst_count", 32'h08, 32'h0);
        rd_chk("rst_ctrl", 32'h00, 32'h0);
        rd_chk("rst_preset", 32'h04, 32'h0);
        cyc(12);
        rd_chk("rst_no_pend", 32'hF0, 32'h0);
        irq_chk("rst_irq", 1'b0);

`ifdef TIMER_ARRAY_PRESCALE_EN
        wr(32'h0C, 32'd3);
        rd_chk("psc_rw", 32'h0C, 32'd3);
        wr(32'h04, 32'd2);
        wr(32'h00, 32'h9);
        cyc(4);
        rd_chk("psc_count_t4", 32'h08, 32'd2);
        cyc(1);
        rd_chk("psc_count_t5", 32'h08, 32'd1);
        cyc(3);
        rd_chk("psc_pend_t8", 32'hF0, 32'h0);
        cyc(1);
        rd_chk("psc_pend_t9", 32'hF0, 32'h1);
`else
        wr(32'h0C, 32'd3);
        rd_chk("psc_disabled", 32'h0C, 32'h0);
        wr(32'h04, 32'd2);
        wr(32'h00, 32'h9);
        cyc(2);
        rd_chk("nopsc_pend_t2", 32'hF0, 32'h0);
        cyc(1);
        rd_chk("nopsc_pend_t3", 32'hF0, 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
